// File: rtl/pipelined_subtractor_pkg.sv
// Shared definitions for the nibble-pipelined subtractor and the execute stage.
// Holds the operand geometry, the result-flag payload and the subtrahend store layout.
package pipelined_subtractor_pkg;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned SLICE  = 4;
   localparam int unsigned STAGES = WIDTH / SLICE;

   typedef struct packed {
      logic borrow;
      logic zero;
      logic overflow;
   } sub_flags_t;

   // Stage k keeps WIDTH-k*SLICE subtrahend bits; they are packed back to back in one vector.
   function automatic int unsigned b_off(input int unsigned k);
      return k * WIDTH - (SLICE * (k * k - k)) / 2;
   endfunction

   localparam int unsigned B_BITS = b_off(STAGES);

endpackage

// File: rtl/pipelined_subtractor_sub_slice.sv
// Combinational SLICE-bit carry-lookahead slice computing a + ~b + c.
// Caller supplies the inverted subtrahend; carry out of the slice is "no borrow".
module sub_slice
   import pipelined_subtractor_pkg::*;
(
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] nb_i,
   input  logic             c_i,
   output logic [SLICE-1:0] diff_o,
   output logic             c_o,
   output logic             zero_o
);

   logic [SLICE-1:0] gen;
   logic [SLICE-1:0] prop;
   logic [SLICE:0]   carry;
   logic             term;
   logic             acc;

   assign gen  = a_i & nb_i;
   assign prop = a_i ^ nb_i;

   // Each carry is a flat sum of generate terms plus the propagated carry-in.
   always_comb begin
      carry    = '0;
      term     = 1'b0;
      acc      = 1'b0;
      carry[0] = c_i;
      for (int i = 0; i < SLICE; i++) begin
         acc = c_i;
         for (int j = 0; j <= i; j++) begin
            acc = acc & prop[j];
         end
         for (int j = 0; j <= i; j++) begin
            term = gen[j];
            for (int m = j + 1; m <= i; m++) begin
               term = term & prop[m];
            end
            acc = acc | term;
         end
         carry[i+1] = acc;
      end
   end

   assign diff_o = prop ^ carry[SLICE-1:0];
   assign c_o    = carry[SLICE];
   assign zero_o = ~|diff_o;

endmodule

// File: rtl/pipelined_subtractor.sv
// Eight-stage subtractor resolving one nibble per clock with skewed operands,
// deskewed results, incremental zero detect and a global output-driven stall.
module pipelined_subtractor
   import pipelined_subtractor_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero,
   output logic             overflow
);

   localparam int unsigned LAST = STAGES - 1;
   localparam int unsigned MSB  = WIDTH - 1;

   if (WIDTH % SLICE != 0) begin : g_bad_geometry
      $error("WIDTH must be a multiple of SLICE");
   end

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [STAGES-1:0] zacc_q, zacc_d;
   logic [STAGES-1:0] amsb_q, amsb_d;
   logic [STAGES-1:0] bmsb_q, bmsb_d;
   // Low k slices hold results, upper slices hold the unconsumed minuend.
   logic [WIDTH-1:0]  word_q [STAGES];
   logic [WIDTH-1:0]  word_d [STAGES];
   logic [B_BITS-1:0] brem_q, brem_d;

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   sub_flags_t        flags_q, flags_d;

   logic [SLICE-1:0]  sdiff [STAGES];
   logic [STAGES-1:0] scarry;
   logic [STAGES-1:0] szero;
   logic [WIDTH-1:0]  word_nxt [STAGES];
   logic              stall;

   assign stall    = out_valid_q & ~out_ready;
   assign in_ready = ~stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned OFF = b_off(k);
      localparam int unsigned REM = WIDTH - k * SLICE;

      if (k == 0) begin : g_first
         assign brem_d[OFF +: REM] = stall ? brem_q[OFF +: REM] : b;
      end else begin : g_rest
         localparam int unsigned SRC = b_off(k - 1) + SLICE;
         assign brem_d[OFF +: REM] = stall ? brem_q[OFF +: REM] : brem_q[SRC +: REM];
      end

      sub_slice u_slice (
         .a_i    (word_q[k][k*SLICE +: SLICE]),
         .nb_i   (~brem_q[OFF +: SLICE]),
         .c_i    (carry_q[k]),
         .diff_o (sdiff[k]),
         .c_o    (scarry[k]),
         .zero_o (szero[k])
      );
   end

   // Drop each stage's fresh result nibble into its word.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         word_nxt[k] = word_q[k];
         word_nxt[k][k*SLICE +: SLICE] = sdiff[k];
      end
   end

   // Next state: hold everything on stall, otherwise shift one stage.
   always_comb begin
      valid_d     = valid_q;
      carry_d     = carry_q;
      zacc_d      = zacc_q;
      amsb_d      = amsb_q;
      bmsb_d      = bmsb_q;
      word_d      = word_q;
      out_valid_d = out_valid_q;
      diff_d      = diff_q;
      flags_d     = flags_q;

      if (!stall) begin
         valid_d[0] = in_valid;
         carry_d[0] = ~borrow_in;
         zacc_d[0]  = 1'b1;
         amsb_d[0]  = a[MSB];
         bmsb_d[0]  = b[MSB];
         word_d[0]  = a;
         for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            carry_d[k] = scarry[k-1];
            zacc_d[k]  = zacc_q[k-1] & szero[k-1];
            amsb_d[k]  = amsb_q[k-1];
            bmsb_d[k]  = bmsb_q[k-1];
            word_d[k]  = word_nxt[k-1];
         end

         out_valid_d      = valid_q[LAST];
         diff_d           = word_nxt[LAST];
         flags_d.borrow   = ~scarry[LAST];
         flags_d.zero     = zacc_q[LAST] & szero[LAST];
         flags_d.overflow = (amsb_q[LAST] != bmsb_q[LAST]) &&
                            (word_nxt[LAST][MSB] != amsb_q[LAST]);
      end
   end

   // Datapath registers carry don't-care data in bubble slots, so no reset.
   always_ff @(posedge clk) begin
      word_q  <= word_d;
      brem_q  <= brem_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         flags_q     <= '0;
      end else begin
         valid_q     <= valid_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign diff       = diff_q;
   assign borrow_out = flags_q.borrow;
   assign zero       = flags_q.zero;
   assign overflow   = flags_q.overflow;

endmodule
